// File: rtl/inst_fetch_pkg.sv
// Shared fetch types: default reset PC, widths and the {inst, pc} queue entry.
package fetch_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          INST_W   = 32;
    localparam int          PC_W     = 32;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fq_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: ROM port, redirect request and the decode handshake.
interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_inst;
    logic [31:0]           out_pc;

    modport master (
        output rom_addr, input rom_data,
        input  redirect_valid, input redirect_pc,
        output out_valid, input out_ready, output out_inst, output out_pc
    );
    modport slave (
        input  rom_addr, output rom_data,
        output redirect_valid, output redirect_pc,
        input  out_valid, output out_ready, input out_inst, input out_pc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Small circular FIFO of fetched {inst, pc} entries; clear wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  fq_entry_t     din_i,
    output logic [CW-1:0] count_o,
    output fq_entry_t     head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop_i) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: drives a synchronous ROM, tracks one in-flight read and
// buffers returned words in a small queue in front of decode.
module inst_fetch #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter int          QDEPTH     = 2
) (
    input  logic         rawclk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);
    import fetch_pkg::*;

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int OW = CW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          req_v_q, req_v_d;
    logic [31:0]   redir_pc;
    logic [CW-1:0] count;
    logic [OW-1:0] occ;
    logic          pop, push, issue;
    fq_entry_t     push_ent, head;

    assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
    assign pop      = bus.out_valid & bus.out_ready;
    assign push     = req_v_q & ~bus.redirect_valid;

    // count + req_v - pop < QDEPTH, rearranged to stay unsigned
    assign occ   = OW'(count) + OW'(req_v_q);
    assign issue = ~bus.redirect_valid && (occ < OW'(QDEPTH) + OW'(pop));

    assign bus.rom_addr = !rst_n             ? RESET_PC[ADDR_WIDTH+1:2] :
                          bus.redirect_valid ? redir_pc[ADDR_WIDTH+1:2] :
                                               fetch_pc_q[ADDR_WIDTH+1:2];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_v_d    = 1'b0;
        if (bus.redirect_valid) begin
            req_v_d    = 1'b1;
            req_pc_d   = redir_pc;
            fetch_pc_d = redir_pc + 32'd4;
        end else if (issue) begin
            req_v_d    = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge rawclk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            req_v_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            req_v_q    <= req_v_d;
        end
    end

    assign push_ent.inst = INST_W'(bus.rom_data);
    assign push_ent.pc   = req_pc_q;

    fetch_queue #(.DEPTH(QDEPTH), .CW(CW)) u_queue (
        .clk     (rawclk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop & ~bus.redirect_valid),
        .clear_i (bus.redirect_valid),
        .din_i   (push_ent),
        .count_o (count),
        .head_o  (head)
    );

    assign bus.out_valid = (count != '0);
    assign bus.out_inst  = DATA_WIDTH'(head.inst);
    assign bus.out_pc    = head.pc;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a stream-level model of expected pc/inst.
module tb_inst_fetch;
    logic rawclk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;
    int   mchk = 0;
    logic [31:0] exp_pc;

    inst_fetch_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    inst_fetch #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(32'h0), .QDEPTH(2)
    ) dut (
        .rawclk (rawclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 rawclk = ~rawclk;

    // Synchronous ROM: word k holds 0x1000_0000 + k
    always @(posedge rawclk) bus.rom_data <= 32'h1000_0000 + 32'(bus.rom_addr);

    function automatic logic [31:0] romw(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h3FF);
    endfunction

    // Stream model: delivered pcs are consecutive from reset pc or the last
    // redirect target (low bits cleared); each accepted word advances by 4.
    always @(posedge rawclk or negedge rst_n) begin
        if (!rst_n)                              exp_pc <= 32'h0;
        else if (bus.redirect_valid)             exp_pc <= bus.redirect_pc & ~32'h3;
        else if (bus.out_valid && bus.out_ready) exp_pc <= exp_pc + 32'd4;
    end

    always @(negedge rawclk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            nchk++;
            mchk++;
            if (bus.out_pc !== exp_pc || bus.out_inst !== romw(exp_pc)) begin
                nerr++;
                $display("FAIL model_stream: got pc=%h inst=%h want pc=%h inst=%h",
                         bus.out_pc, bus.out_inst, exp_pc, romw(exp_pc));
            end
        end
    end

    task automatic tick();
        @(posedge rawclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'b1011_0010_1110_0110;
        rst_n = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (2) tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_inst", bus.out_inst, 32'h0);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        #1;
        chk("rst_rom_addr_redir", 32'(bus.rom_addr), 32'd0);
        bus.redirect_valid = 1'b0;
        rst_n = 1'b1;

        // reset release: first word visible after the second edge
        tick();
        chk("rel_e1_valid", 32'(bus.out_valid), 32'd0);
        chk("rel_e1_rom_addr", 32'(bus.rom_addr), 32'd1);
        tick();
        chk("rel_e2_valid", 32'(bus.out_valid), 32'd1);
        chk("rel_e2_pc", bus.out_pc, 32'h0);
        chk("rel_e2_inst", bus.out_inst, 32'h1000_0000);
        tick();
        chk("rel_e3_pc", bus.out_pc, 32'h4);
        chk("rel_e3_inst", bus.out_inst, 32'h1000_0001);

        // decode stall: outputs and ROM address hold
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", bus.out_pc, 32'h4);
            chk("stall_inst", bus.out_inst, 32'h1000_0001);
            chk("stall_rom_addr", 32'(bus.rom_addr), 32'd3);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("unstall_pc8", bus.out_pc, 32'h8);
        tick();
        chk("unstall_pc12", bus.out_pc, 32'hC);

        // redirect alongside a pop and a push
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        chk("redirA_rom_addr", 32'(bus.rom_addr), 32'd16);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("redirA_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("redirA_rom_addr_next", 32'(bus.rom_addr), 32'd17);
        tick();
        chk("redirA_pc", bus.out_pc, 32'h40);
        chk("redirA_inst", bus.out_inst, 32'h1000_0010);
        tick();
        chk("redirA_pc2", bus.out_pc, 32'h44);
        chk("redirA_inst2", bus.out_inst, 32'h1000_0011);

        // redirect with a full queue, target at the top of the ROM
        bus.out_ready = 1'b0;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFC;
        #1;
        chk("redirB_rom_addr", 32'(bus.rom_addr), 32'd1023);
        tick();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        #1;
        chk("redirB_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("redirB_rom_addr_wrap", 32'(bus.rom_addr), 32'd0);
        tick();
        chk("redirB_pc", bus.out_pc, 32'hFFC);
        chk("redirB_inst", bus.out_inst, 32'h1000_03FF);
        tick();
        chk("redirB_pc2", bus.out_pc, 32'h1000);
        chk("redirB_inst2", bus.out_inst, 32'h1000_0000);

        // unaligned target near 2^32: low bits dropped, pc wraps to 0
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        #1;
        chk("redirC_rom_addr", 32'(bus.rom_addr), 32'h3FF);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("redirC_flush_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("redirC_pc", bus.out_pc, 32'hFFFF_FFFC);
        chk("redirC_inst", bus.out_inst, 32'h1000_03FF);
        tick();
        chk("redirC_pc2", bus.out_pc, 32'h0);
        chk("redirC_inst2", bus.out_inst, 32'h1000_0000);

        // reset pulse mid-stream
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_pc", bus.out_pc, 32'h0);
        chk("midrst_inst", bus.out_inst, 32'h0);
        chk("midrst_rom_addr", 32'(bus.rom_addr), 32'd0);
        tick();
        chk("midrst_hold_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_e1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("midrst_e2_valid", 32'(bus.out_valid), 32'd1);
        chk("midrst_e2_pc", bus.out_pc, 32'h0);
        chk("midrst_e2_inst", bus.out_inst, 32'h1000_0000);
        tick();
        chk("midrst_e3_pc", bus.out_pc, 32'h4);

        // irregular decode backpressure, checked by the stream model
        for (int i = 0; i < 16; i++) begin
            bus.out_ready = pat[i];
            tick();
        end
        bus.out_ready = 1'b1;
        repeat (4) tick();
        @(negedge rawclk);
        #1;
        chk("model_checks_ran", 32'(mchk > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
